// File: rtl/spectrum_frame_parser_pkg.sv
// spectrum_pkg: shared defaults and one-hot FSM encoding for the spectrum frame parser
package spectrum_pkg;
  localparam int NUM_BINS_D = 32;
  localparam logic [7:0] SYNC0_D = 8'hA5;
  localparam logic [7:0] SYNC1_D = 8'h5A;
  localparam int TIMEOUT_D = 8760;
  typedef enum logic [3:0] {
    WAIT_SYNC0 = 4'b0001,
    WAIT_SYNC1 = 4'b0010,
    PAYLOAD    = 4'b0100,
    CHECK      = 4'b1000
  } state_t;
endpackage

// File: rtl/spectrum_frame_parser_if.sv
// spectrum_frame_parser_if: byte stream in, renderer read port and frame status out
interface spectrum_frame_parser_if #(parameter int NUM_BINS = spectrum_pkg::NUM_BINS_D);
  logic byte_valid;
  logic [7:0] byte_data;
  logic [$clog2(NUM_BINS)-1:0] rd_addr;
  logic [7:0] rd_data;
  logic frame_valid;
  logic frame_error;
  modport master (output byte_valid, byte_data, rd_addr, input rd_data, frame_valid, frame_error);
  modport slave (input byte_valid, byte_data, rd_addr, output rd_data, frame_valid, frame_error);
endinterface

// File: rtl/spectrum_frame_parser_ram.sv
// spectrum_bin_ram: two bin buffers in one simple dual-port RAM; address MSB selects the buffer
module spectrum_bin_ram #(parameter int NUM_BINS = 32, parameter int AW = $clog2(NUM_BINS) + 1) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [2*NUM_BINS];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/spectrum_frame_parser.sv
// spectrum_frame_parser: parses sync/payload/checksum frames into a double-buffered bin RAM
module spectrum_frame_parser import spectrum_pkg::*; #(
  parameter int NUM_BINS = NUM_BINS_D,
  parameter logic [7:0] SYNC0 = SYNC0_D,
  parameter logic [7:0] SYNC1 = SYNC1_D,
  parameter int TIMEOUT_CYCLES = TIMEOUT_D
) (
  input logic clk,
  input logic resetn,
  spectrum_frame_parser_if.slave io_bus
);
  localparam int IW = $clog2(NUM_BINS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_st, w_nxt;
  logic [IW-1:0] r_idx;
  logic [7:0] r_sum, w_b, w_q;
  logic [TW-1:0] r_tmo;
  logic r_sel, r_first, r_show, r_fv, r_fe;
  logic w_bv, w_tmo, w_good, w_bad, w_we;
  assign w_bv = io_bus.byte_valid;
  assign w_b = io_bus.byte_data;
  always_comb begin
    w_nxt = r_st;
    w_good = 1'b0;
    w_tmo = r_st != WAIT_SYNC0 && !w_bv && r_tmo == TW'(TIMEOUT_CYCLES - 1);
    w_bad = w_tmo;
    w_we = w_bv && r_st == PAYLOAD;
    if (w_tmo) w_nxt = WAIT_SYNC0;
    else if (w_bv)
      case (r_st)
        WAIT_SYNC0: w_nxt = w_b == SYNC0 ? WAIT_SYNC1 : WAIT_SYNC0;
        WAIT_SYNC1: w_nxt = w_b == SYNC1 ? PAYLOAD : w_b == SYNC0 ? WAIT_SYNC1 : WAIT_SYNC0;
        PAYLOAD:    w_nxt = r_idx == IW'(NUM_BINS - 1) ? CHECK : PAYLOAD;
        CHECK: begin
          w_nxt = WAIT_SYNC0;
          w_good = w_b == r_sum;
          w_bad = w_b != r_sum;
        end
        default:    w_nxt = WAIT_SYNC0;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_st <= WAIT_SYNC0;
      r_idx <= '0;
      r_sum <= '0;
      r_tmo <= '0;
      r_sel <= 1'b0;
      r_first <= 1'b0;
      r_show <= 1'b0;
      r_fv <= 1'b0;
      r_fe <= 1'b0;
    end else begin
      r_st <= w_nxt;
      r_tmo <= (w_bv || w_tmo || r_st == WAIT_SYNC0) ? '0 : r_tmo + TW'(1);
      r_idx <= w_we ? r_idx + IW'(1) : r_st == PAYLOAD ? r_idx : '0;
      r_sum <= w_we ? r_sum + w_b : (r_st == PAYLOAD || r_st == CHECK) ? r_sum : '0;
      r_sel <= r_sel ^ w_good;
      r_first <= r_first | w_good;
      r_show <= r_first;
      r_fv <= w_good;
      r_fe <= w_bad;
    end
  end
  // writes target the inactive half, reads the active half, so partial frames stay hidden
  spectrum_bin_ram #(.NUM_BINS(NUM_BINS)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({~r_sel, r_idx}),
    .i_wdata (w_b),
    .i_raddr ({r_sel, io_bus.rd_addr}),
    .o_rdata (w_q)
  );
  assign io_bus.rd_data = r_show ? w_q : '0;
  assign io_bus.frame_valid = r_fv;
  assign io_bus.frame_error = r_fe;
endmodule

// File: tb/tb_spectrum_frame_parser.sv
// tb_spectrum_frame_parser: directed scenario tasks with hand-computed expectations
module tb_spectrum_frame_parser;
  logic clk;
  logic resetn;
  int total = 0;
  int bad = 0;
  int n_fv = 0;
  int n_fe = 0;
  int n_both = 0;
  int n_long = 0;
  logic p_fv = 0;
  logic p_fe = 0;
  spectrum_frame_parser_if #(.NUM_BINS(32)) bus ();
  spectrum_frame_parser dut (.clk(clk), .resetn(resetn), .io_bus(bus.slave));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.frame_valid) n_fv++;
    if (bus.frame_error) n_fe++;
    if (bus.frame_valid && bus.frame_error) n_both++;
    if ((bus.frame_valid && p_fv) || (bus.frame_error && p_fe)) n_long++;
    p_fv = bus.frame_valid;
    p_fe = bus.frame_error;
  end
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask
  task automatic send_payload(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v);
  endtask
  task automatic read_bin(input int a, output logic [7:0] d);
    @(posedge clk); #1;
    bus.rd_addr = 5'(a);
    @(posedge clk); #1;
    d = bus.rd_data;
  endtask
  task automatic chk_pulse(input string nm, input logic fv, input logic fe);
    total++;
    if (bus.frame_valid !== fv || bus.frame_error !== fe) begin
      bad++;
      $display("FAIL %s: valid/error got=%b%b exp=%b%b", nm, bus.frame_valid, bus.frame_error, fv, fe);
    end
  endtask
  task automatic chk_bin(input string nm, input int a, input logic [7:0] exp);
    logic [7:0] d;
    read_bin(a, d);
    total++;
    if (d !== exp) begin
      bad++;
      $display("FAIL %s bin %0d: got=%h exp=%h", nm, a, d, exp);
    end
  endtask
  task automatic test_reset;
    logic [7:0] d;
    resetn = 0;
    bus.byte_valid = 0;
    bus.byte_data = 0;
    bus.rd_addr = 0;
    repeat (4) @(posedge clk);
    #1;
    chk_pulse("reset_pulses", 1'b0, 1'b0);
    total++;
    if (bus.rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rd_data: got=%h exp=00", bus.rd_data);
    end
    resetn = 1;
    for (int i = 0; i < 32; i++) chk_bin("reset_bins", i, 8'h00);
  endtask
  task automatic test_ramp;
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    send_byte(8'hF0);
    chk_pulse("ramp_commit", 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_pulse("ramp_one_cycle", 1'b0, 1'b0);
    chk_bin("ramp", 5, 8'h05);
    chk_bin("ramp", 31, 8'h1F);
  endtask
  task automatic test_bad_checksum;
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(8'h10, 32);
    send_byte(8'h00);
    chk_pulse("const10_commit", 1'b1, 1'b0);
    chk_bin("const10", 7, 8'h10);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(8'h20, 32);
    send_byte(8'h01);
    chk_pulse("bad_cks", 1'b0, 1'b1);
    chk_bin("bad_cks_kept", 7, 8'h10);
    chk_bin("bad_cks_kept", 0, 8'h10);
  endtask
  task automatic test_resync;
    send_byte(8'h12);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(8'h01, 32);
    send_byte(8'h20);
    chk_pulse("resync_commit", 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) chk_bin("resync", i, 8'h01);
  endtask
  task automatic test_timeout;
    int lat = -1;
    int fe0;
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(8'h33, 10);
    fe0 = n_fe;
    for (int k = 1; k <= 9000; k++) begin
      @(posedge clk); #1;
      if (bus.frame_error) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 8760) begin
      bad++;
      $display("FAIL timeout_latency: got=%0d exp=8760", lat);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (n_fe - fe0 != 1) begin
      bad++;
      $display("FAIL timeout_pulses: got=%0d exp=1", n_fe - fe0);
    end
    chk_bin("timeout_kept", 3, 8'h01);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(8'h44, 32);
    send_byte(8'h80);
    chk_pulse("after_timeout_commit", 1'b1, 1'b0);
    chk_bin("after_timeout", 9, 8'h44);
  endtask
  task automatic test_timeout_boundary;
    send_byte(8'hA5);
    send_byte(8'h5A);
    repeat (8758) @(posedge clk);
    send_payload(8'h02, 32);
    send_byte(8'h40);
    chk_pulse("boundary_commit", 1'b1, 1'b0);
    chk_bin("boundary", 30, 8'h02);
  endtask
  task automatic test_reset_mid;
    int fv0, fe0;
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(8'h77, 20);
    fv0 = n_fv;
    fe0 = n_fe;
    @(posedge clk); #1;
    resetn = 0;
    bus.rd_addr = 5'd4;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.rd_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_rd_data: got=%h exp=00", bus.rd_data);
    end
    resetn = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (n_fv != fv0 || n_fe != fe0) begin
      bad++;
      $display("FAIL mid_reset_pulses: got valid=%0d error=%0d exp 0 0", n_fv - fv0, n_fe - fe0);
    end
    chk_bin("post_reset_masked", 4, 8'h00);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(8'h09, 32);
    send_byte(8'h20);
    chk_pulse("post_reset_commit", 1'b1, 1'b0);
    chk_bin("post_reset", 3, 8'h09);
  endtask
  task automatic test_pulse_rules;
    total++;
    if (n_both != 0 || n_long != 0) begin
      bad++;
      $display("FAIL pulse_rules: overlap=%0d held=%0d exp 0 0", n_both, n_long);
    end
  endtask
  initial begin
    test_reset;
    test_ramp;
    test_bad_checksum;
    test_resync;
    test_timeout;
    test_timeout_boundary;
    test_reset_mid;
    test_pulse_rules;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
